// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_port_arbiter.
// The master modport is the arbiter's view; the slave modport is the view
// of everything around it (fetch stage, load/store stage and memory model).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    // Load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    // Timeout flag, pulsed together with i_done/d_done
    logic              err;
    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_done, i_rdata, d_done, d_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_done, i_rdata, d_done, d_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch (I) and the
// load/store (D) requesters. One transaction at a time; D has priority but
// may win at most MAX_D_RUN grants in a row while I is waiting. A watchdog
// aborts a transaction whose mem_ack does not arrive within TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_D_RUN = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_D_RUN_C = 4'(MAX_D_RUN);
    localparam logic [7:0] TMO_LAST_C  = 8'(TIMEOUT - 1);

    state_t            state_r, state_nxt_s;
    logic [3:0]        d_run_r, d_run_nxt_s;
    logic [7:0]        tmo_r, tmo_nxt_s;
    logic              mem_req_r, mem_req_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic [DATA_W-1:0] i_rdata_r, i_rdata_nxt_s;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_nxt_s;
    logic              i_done_r, i_done_nxt_s;
    logic              d_done_r, d_done_nxt_s;
    logic              err_r, err_nxt_s;
    logic              grant_d_s, grant_i_s, tmo_hit_s;

    // D wins unless I is waiting and D has used up its consecutive-grant budget
    assign grant_d_s = bus.d_req && (!bus.i_req || (d_run_r < MAX_D_RUN_C));
    assign grant_i_s = bus.i_req && !grant_d_s;
    assign tmo_hit_s = (tmo_r == TMO_LAST_C);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision: arbitrate in IDLE, leave BUSY on ack or timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = BUSY_D;
                end else if (grant_i_s) begin
                    state_nxt_s = BUSY_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack || tmo_hit_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of every registered output and of the run/timeout counters
    always_comb begin
        mem_req_nxt_s   = mem_req_r;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        i_rdata_nxt_s   = i_rdata_r;
        d_rdata_nxt_s   = d_rdata_r;
        i_done_nxt_s    = 1'b0;
        d_done_nxt_s    = 1'b0;
        err_nxt_s       = 1'b0;
        d_run_nxt_s     = d_run_r;
        tmo_nxt_s       = tmo_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = bus.d_we;
                    mem_addr_nxt_s  = {bus.d_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_nxt_s = bus.d_wdata;
                    d_run_nxt_s     = (d_run_r == 4'd15) ? 4'd15 : d_run_r + 4'd1;
                end else if (grant_i_s) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = 1'b0;
                    mem_addr_nxt_s  = {bus.i_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_nxt_s = {DATA_W{1'b0}};
                    d_run_nxt_s     = 4'd0;
                end else begin
                    d_run_nxt_s     = d_run_r;
                end
            end
            BUSY_I, BUSY_D: begin
                tmo_nxt_s = tmo_r + 8'd1;
                // An ack in the last watchdog cycle still counts as success
                if (bus.mem_ack) begin
                    mem_req_nxt_s = 1'b0;
                    mem_we_nxt_s  = 1'b0;
                    if (state_r == BUSY_I) begin
                        i_rdata_nxt_s = bus.mem_rdata;
                        i_done_nxt_s  = 1'b1;
                    end else begin
                        d_done_nxt_s  = 1'b1;
                        if (!mem_we_r) begin
                            d_rdata_nxt_s = bus.mem_rdata;
                        end else begin
                            d_rdata_nxt_s = d_rdata_r;
                        end
                    end
                end else if (tmo_hit_s) begin
                    mem_req_nxt_s = 1'b0;
                    mem_we_nxt_s  = 1'b0;
                    err_nxt_s     = 1'b1;
                    if (state_r == BUSY_I) begin
                        i_done_nxt_s = 1'b1;
                    end else begin
                        d_done_nxt_s = 1'b1;
                    end
                end else begin
                    mem_req_nxt_s = mem_req_r;
                end
            end
            RESP: begin
                tmo_nxt_s = 8'd0;
            end
            default: begin
                tmo_nxt_s = 8'd0;
            end
        endcase
    end

    // Output and counter registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            i_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            i_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
            err_r       <= 1'b0;
            d_run_r     <= 4'd0;
            tmo_r       <= 8'd0;
        end else begin
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            i_rdata_r   <= i_rdata_nxt_s;
            d_rdata_r   <= d_rdata_nxt_s;
            i_done_r    <= i_done_nxt_s;
            d_done_r    <= d_done_nxt_s;
            err_r       <= err_nxt_s;
            d_run_r     <= d_run_nxt_s;
            tmo_r       <= tmo_nxt_s;
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.i_done    = i_done_r;
    assign bus.d_done    = d_done_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MAX_D_RUN=4, TIMEOUT=64).
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_RUN(4), .TIMEOUT(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_cyc;   // cycle (1 = first mem_req cycle) carrying mem_ack
        logic [31:0] rdata;     // mem_rdata driven with the ack
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata; // expected i_rdata / d_rdata after done
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, answer it after v.ack_cyc cycles and check the result
    task automatic run_txn(input vec_t v);
        if (v.is_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.i_req   = 1'b1;
            bus.i_addr  = v.addr;
        end
        tick();
        check("mem_req_rise", {31'd0, bus.mem_req}, 32'd1);
        check("mem_addr", bus.mem_addr, v.exp_addr);
        check("mem_we", {31'd0, bus.mem_we}, {31'd0, v.exp_we});
        check("mem_wdata", bus.mem_wdata, v.exp_wdata);
        for (int c = 1; c < v.ack_cyc; c++) begin
            tick();
        end
        check("mem_req_held", {31'd0, bus.mem_req}, 32'd1);
        check("mem_addr_held", bus.mem_addr, v.exp_addr);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.rdata;
        tick();
        bus.mem_ack = 1'b0;
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        check("mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
        check("err_on_ack", {31'd0, bus.err}, 32'd0);
        if (v.is_d) begin
            check("d_done", {31'd0, bus.d_done}, 32'd1);
            check("i_done_quiet", {31'd0, bus.i_done}, 32'd0);
            check("d_rdata", bus.d_rdata, v.exp_rdata);
        end else begin
            check("i_done", {31'd0, bus.i_done}, 32'd1);
            check("d_done_quiet", {31'd0, bus.d_done}, 32'd0);
            check("i_rdata", bus.i_rdata, v.exp_rdata);
        end
        tick();
        check("done_one_cycle", {30'd0, bus.i_done, bus.d_done}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   cnt;
        int   ng;
        logic both_seen;
        logic prev_req;
        logic got_d [10];
        logic exp_ord [10];

        pass_cnt  = 0;
        total_cnt = 0;
        rst           = 1'b1;
        bus.i_req     = 1'b0;
        bus.i_addr    = 32'd0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'd0;
        bus.d_wdata   = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ack   = 1'b0;

        //            is_d  we    addr          wdata         ack rdata         exp_addr      we    exp_wdata     exp_rdata
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0006, 32'h0,        4, 32'h2008_0005, 32'h0000_0004, 1'b0, 32'h0,        32'h2008_0005};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1, 32'h1234_5678, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0043, 32'h0,        2, 32'hDEAD_BEEF, 32'h0000_0040, 1'b0, 32'h0,        32'hDEAD_BEEF};
        tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        1, 32'hA5A5_5A5A, 32'hFFFF_FFFC, 1'b0, 32'h0,        32'hA5A5_5A5A};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_1001, 32'h0,        3, 32'h0BAD_F00D, 32'h0000_1000, 1'b0, 32'h0,        32'h0BAD_F00D};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0082, 32'h55AA_55AA, 1, 32'hFFFF_FFFF, 32'h0000_0080, 1'b1, 32'h55AA_55AA, 32'h0BAD_F00D};

        // Reset state
        tick();
        tick();
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_dones", {29'd0, bus.i_done, bus.d_done, bus.err}, 32'd0);
        check("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single transactions
        for (int k = 0; k < 6; k++) begin
            run_txn(tbl[k]);
        end

        // Timeout: load that never gets an ack
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0300;
        tick();
        cnt = 0;
        while (bus.mem_req && cnt < 100) begin
            cnt++;
            tick();
        end
        check("tmo_req_cycles", cnt, 32'd64);
        check("tmo_d_done", {31'd0, bus.d_done}, 32'd1);
        check("tmo_err", {31'd0, bus.err}, 32'd1);
        check("tmo_i_done_quiet", {31'd0, bus.i_done}, 32'd0);
        check("tmo_d_rdata_kept", bus.d_rdata, 32'h0BAD_F00D);
        bus.d_req = 1'b0;
        tick();
        check("tmo_err_pulse", {30'd0, bus.err, bus.d_done}, 32'd0);

        // Fetch after the timeout is served normally
        v = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 1, 32'hCAFE_0001, 32'h0000_0008, 1'b0, 32'h0, 32'hCAFE_0001};
        run_txn(v);

        // Ack in the last watchdog cycle wins over the timeout
        v = '{1'b1, 1'b0, 32'h0000_0304, 32'h0, 64, 32'h600D_CAFE, 32'h0000_0304, 1'b0, 32'h0, 32'h600D_CAFE};
        run_txn(v);

        // Stray ack while idle
        bus.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stray_ack_idle", {29'd0, bus.i_done, bus.d_done, bus.mem_req}, 32'd0);
        end
        bus.mem_ack = 1'b0;

        // Asynchronous reset in the middle of a fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0010;
        tick();
        check("rstmid_req_up", {31'd0, bus.mem_req}, 32'd1);
        tick();
        tick();
        #3;
        rst       = 1'b1;
        bus.i_req = 1'b0;
        #1;
        check("rstmid_req_drop", {31'd0, bus.mem_req}, 32'd0);
        check("rstmid_done_err", {30'd0, bus.i_done, bus.err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_no_done", {30'd0, bus.i_done, bus.d_done}, 32'd0);
        rst = 1'b0;
        v = '{1'b0, 1'b0, 32'h0000_0014, 32'h0, 2, 32'h1357_9BDF, 32'h0000_0014, 1'b0, 32'h0, 32'h1357_9BDF};
        run_txn(v);

        // Contention with a 1-cycle memory: D,D,D,D,I,D,D,D,D,I
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 10; k++) begin
            got_d[k] = 1'b0;
        end
        ng        = 0;
        both_seen = 1'b0;
        prev_req  = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0200;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0100;
        bus.mem_rdata = 32'h0000_00AA;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.i_done && bus.d_done) begin
                both_seen = 1'b1;
            end
            if (bus.mem_req && !prev_req && ng < 10) begin
                got_d[ng] = (bus.mem_addr == 32'h0000_0100);
                ng++;
            end
            prev_req    = bus.mem_req;
            bus.mem_ack = bus.mem_req;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.mem_ack = bus.mem_req;
        end
        bus.mem_ack = 1'b0;
        check("cont_grants", ng, 32'd10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("cont_order_%0d", k), {31'd0, got_d[k]}, {31'd0, exp_ord[k]});
        end
        check("cont_no_double_done", {31'd0, both_seen}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (I-port) and the load/store requester (D-port) of the core.
- Sits between the fetch/memory stages and the memory model. Sequences one transaction at a time with a req/done handshake on each side and a req/ack handshake toward memory.
- Includes fixed priority with a starvation guard and an ack-timeout watchdog.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MAX_D_RUN, 4, maximum number of consecutive D-port grants while I-port is pending; range 1..15.
- TIMEOUT, 64, cycles to wait for mem_ack before aborting; range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held high until i_done
- i_addr  in  ADDR_W  fetch byte address
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  fetched word
- d_req  in  1  load/store request; held high until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data, valid with d_done
- err  out  1  one-cycle pulse with i_done/d_done when the access timed out
- mem_req  out  1  memory request; held until mem_ack or abort
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, one cycle

Behaviour:
- Reset (async):
  - State = IDLE.
  - All outputs = 0; i_rdata and d_rdata = 0.
  - d_run counter = 0; timeout counter = 0.
- Reset mid-transaction: the transaction is abandoned and no done is pulsed. Requesters re-issue after reset.
- States:
  - IDLE
  - BUSY_I
  - BUSY_D
  - RESP: single cycle in which done is pulsed.
- IDLE arbitration, evaluated every cycle:
  - If d_req and (!i_req or d_run < MAX_D_RUN): grant D.
  - Else if i_req: grant I.
  - Else stay in IDLE.
- Grant actions:
  - Register addr, we and wdata from the granted port.
  - Assert mem_req from the next cycle (registered outputs).
  - Go to BUSY_x.
  - On a D grant: d_run++ (saturating at 15).
  - On an I grant: d_run = 0.
  - When an I grant occurs with i_req low, d_run resets to 0 only on I grant; an idle cycle does not clear it.
  - For I transactions, mem_we = 0 always.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the exit cycle.
  - The timeout counter increments each cycle.
  - mem_ack=1: capture mem_rdata into x_rdata (d_rdata is updated for loads only), drop mem_req, go to RESP.
  - Counter reaches TIMEOUT-1 without ack: drop mem_req, go to RESP with err flagged. x_rdata is unchanged.
  - If mem_ack and the timeout fire in the same cycle, the ack wins and err = 0.
- RESP:
  - Pulse x_done = 1 for exactly one cycle; err pulses too if flagged.
  - Clear the timeout counter; go to IDLE.
  - The requester drops its req in the cycle after done. IDLE ignores a req in the RESP cycle.
  - Minimum turnaround is therefore grant -> next grant in 1 + latency + 1 + 1 cycles.
- mem_ack received while in IDLE or RESP (stale or late ack) is ignored.
- Latency: with the request seen in IDLE at cycle 0, mem_req is high in cycle 1. If mem_ack arrives in cycle k, x_done is high in cycle k+1.
- Only one port can be done in any cycle. i_done and d_done are never high together.
- A req dropped before done is a protocol violation. The transaction completes regardless.

Test Plan:
- Single fetch: i_req, i_addr=0x0000_0006, mem_ack after 3 cycles with mem_rdata=0x2008_0005 -> mem_addr=0x0000_0004, mem_we=0, i_done in cycle 5, i_rdata=0x2008_0005, err=0.
- Store then load: d_req with d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_wdata=0xDEAD_BEEF, d_done. Then a load of 0x40 with mem_rdata=0xDEAD_BEEF -> d_rdata=0xDEAD_BEEF.
- Contention: i_req and d_req held continuously, MAX_D_RUN=4, 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I. No cycle has both dones set.
- Timeout: d_req with mem_ack never asserted, TIMEOUT=64 -> mem_req high for 64 cycles then low, d_done=1 and err=1 in the same cycle, d_rdata unchanged. The next i_req is served normally.
- Ack at the timeout edge: mem_ack in the 64th BUSY cycle -> done with err=0. A stray mem_ack in IDLE produces no done.
- Reset mid-BUSY_I: assert rst asynchronously -> mem_req, i_done and err drop immediately. After release, state is IDLE and a re-issued i_req completes normally.
